// File: rtl/cfo_pkg.sv
// Shared widths, saturation bounds and rounding constant for the carrier-offset derotator.
package cfo_pkg;

  localparam int DW_DEF   = 12;  // sample width (I and Q)
  localparam int NW_DEF   = 12;  // NCO cos/sin word width
  localparam int FRAC_DEF = 11;  // fractional bits of NCO word (Q1.11)
  localparam int CW_DEF   = 16;  // saturation event counter width

  // Largest representable signed value for a given width.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Smallest representable signed value for a given width.
  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

  // Half an LSB of the output, added before the shift for round-half-up.
  function automatic int rnd_const(input int frac);
    return 1 << (frac - 1);
  endfunction

  localparam int SAT_MAX_DEF = sat_max(DW_DEF);
  localparam int SAT_MIN_DEF = sat_min(DW_DEF);
  localparam int RND_DEF     = rnd_const(FRAC_DEF);

endpackage

// File: rtl/cfo_rnd_sat.sv
// Combinational round-half-up and clamp of a wide signed sum down to a DW-bit sample.
module cfo_rnd_sat
  import cfo_pkg::*;
#(
  parameter int SW   = 25,
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic signed [SW-1:0] sum_in,
  output logic signed [DW-1:0] y,
  output logic                 sat
);

  localparam logic signed [SW-1:0] RND = SW'(rnd_const(FRAC));
  localparam logic signed [SW-1:0] HI  = SW'(sat_max(DW));
  localparam logic signed [SW-1:0] LO  = SW'(sat_min(DW));

  logic signed [SW-1:0] rounded;
  logic signed [SW-1:0] shifted;

  // Add half an LSB, drop FRAC bits with sign, then clamp into the DW-bit range.
  always_comb begin
    rounded = sum_in + RND;
    shifted = rounded >>> FRAC;
    y       = shifted[DW-1:0];
    sat     = 1'b0;
    if (shifted > HI) begin
      y   = HI[DW-1:0];
      sat = 1'b1;
    end else if (shifted < LO) begin
      y   = LO[DW-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/cfo_mixer.sv
// Carrier-offset derotator: x * e^(-j*theta) through a 3-stage registered complex
// multiplier with round/saturate, backpressure, bypass and a saturation event counter.
module cfo_mixer
  import cfo_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NW   = NW_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_i,
  input  logic signed [DW-1:0] in_q,
  input  logic signed [NW-1:0] ncos,
  input  logic signed [NW-1:0] nsin,
  output logic                 nco_en,
  input  logic                 bypass,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_i,
  output logic signed [DW-1:0] out_q,
  output logic [CW-1:0]        sat_cnt,
  input  logic                 sat_clr
);

  localparam int PW = DW + NW;  // product width
  localparam int SW = PW + 1;   // sum width, wide enough for two full-scale products
  localparam logic [CW-1:0] CNT_MAX = '1;

  // Sign-extended full-width product; operands widened first so the multiply is exact.
  function automatic logic signed [PW-1:0] smul(input logic signed [DW-1:0] a,
                                                input logic signed [NW-1:0] b);
    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] bx;
    ax = {{NW{a[DW-1]}}, a};
    bx = {{DW{b[NW-1]}}, b};
    return ax * bx;
  endfunction

  // One-bit sign extension of a product into the sum width.
  function automatic logic signed [SW-1:0] ext1(input logic signed [PW-1:0] p);
    return {p[PW-1], p};
  endfunction

  // Whole pipeline moves together; it only freezes when a valid output is refused.
  logic advance;
  logic xfer;

  // S1: captured inputs, NCO words and bypass flag.
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_byp_q,   s1_byp_d;
  logic signed [DW-1:0] s1_i_q,     s1_i_d;
  logic signed [DW-1:0] s1_q_q,     s1_q_d;
  logic signed [NW-1:0] s1_c_q,     s1_c_d;
  logic signed [NW-1:0] s1_s_q,     s1_s_d;

  // S2: four partial products plus the raw sample for the bypass path.
  logic                 s2_valid_q, s2_valid_d;
  logic                 s2_byp_q,   s2_byp_d;
  logic signed [DW-1:0] s2_i_q,     s2_i_d;
  logic signed [DW-1:0] s2_q_q,     s2_q_d;
  logic signed [PW-1:0] s2_ic_q,    s2_ic_d;
  logic signed [PW-1:0] s2_qs_q,    s2_qs_d;
  logic signed [PW-1:0] s2_qc_q,    s2_qc_d;
  logic signed [PW-1:0] s2_is_q,    s2_is_d;

  // S3: output registers and per-sample saturation flag.
  logic                 out_valid_q, out_valid_d;
  logic signed [DW-1:0] out_i_q,     out_i_d;
  logic signed [DW-1:0] out_q_q,     out_q_d;
  logic                 out_sat_q,   out_sat_d;
  logic [CW-1:0]        sat_cnt_q,   sat_cnt_d;

  // Lane 0 is I, lane 1 is Q.
  logic signed [SW-1:0] sum_w [2];
  logic signed [DW-1:0] rs_y  [2];
  logic                 rs_sat[2];

  assign advance   = out_ready | ~out_valid_q;
  assign in_ready  = advance;
  assign nco_en    = in_valid & advance;
  assign xfer      = out_valid_q & out_ready;

  assign out_valid = out_valid_q;
  assign out_i     = out_i_q;
  assign out_q     = out_q_q;
  assign sat_cnt   = sat_cnt_q;

  // S1 next state: take a new sample (or a bubble) whenever the pipeline advances.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_byp_d   = s1_byp_q;
    s1_i_d     = s1_i_q;
    s1_q_d     = s1_q_q;
    s1_c_d     = s1_c_q;
    s1_s_d     = s1_s_q;
    if (advance) begin
      s1_valid_d = in_valid;
      s1_byp_d   = bypass;
      s1_i_d     = in_i;
      s1_q_d     = in_q;
      s1_c_d     = ncos;
      s1_s_d     = nsin;
    end
  end

  // S2 next state: form the four products of the conjugate rotation.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_byp_d   = s2_byp_q;
    s2_i_d     = s2_i_q;
    s2_q_d     = s2_q_q;
    s2_ic_d    = s2_ic_q;
    s2_qs_d    = s2_qs_q;
    s2_qc_d    = s2_qc_q;
    s2_is_d    = s2_is_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      s2_byp_d   = s1_byp_q;
      s2_i_d     = s1_i_q;
      s2_q_d     = s1_q_q;
      s2_ic_d    = smul(s1_i_q, s1_c_q);
      s2_qs_d    = smul(s1_q_q, s1_s_q);
      s2_qc_d    = smul(s1_q_q, s1_c_q);
      s2_is_d    = smul(s1_i_q, s1_s_q);
    end
  end

  // Sums for x * conj(e^(j*theta)): I = i*c + q*s, Q = q*c - i*s.
  always_comb begin
    sum_w[0] = ext1(s2_ic_q) + ext1(s2_qs_q);
    sum_w[1] = ext1(s2_qc_q) - ext1(s2_is_q);
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rnd
    cfo_rnd_sat #(
      .SW   (SW),
      .DW   (DW),
      .FRAC (FRAC)
    ) u_rnd_sat (
      .sum_in (sum_w[gi]),
      .y      (rs_y[gi]),
      .sat    (rs_sat[gi])
    );
  end

  // S3 next state: load rotated (or bypassed) result; bypassed samples never flag saturation.
  always_comb begin
    out_valid_d = out_valid_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    out_sat_d   = out_sat_q;
    if (advance) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        if (s2_byp_q) begin
          out_i_d   = s2_i_q;
          out_q_d   = s2_q_q;
          out_sat_d = 1'b0;
        end else begin
          out_i_d   = rs_y[0];
          out_q_d   = rs_y[1];
          out_sat_d = rs_sat[0] | rs_sat[1];
        end
      end
    end
  end

  // Saturation counter: counts delivered saturated samples, sticks at max, clear wins.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (xfer && out_sat_q && (sat_cnt_q != CNT_MAX)) begin
      sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  // Pipeline and counter registers; reset drops every in-flight sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_byp_q    <= 1'b0;
      s1_i_q      <= '0;
      s1_q_q      <= '0;
      s1_c_q      <= '0;
      s1_s_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_byp_q    <= 1'b0;
      s2_i_q      <= '0;
      s2_q_q      <= '0;
      s2_ic_q     <= '0;
      s2_qs_q     <= '0;
      s2_qc_q     <= '0;
      s2_is_q     <= '0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_sat_q   <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_byp_q    <= s1_byp_d;
      s1_i_q      <= s1_i_d;
      s1_q_q      <= s1_q_d;
      s1_c_q      <= s1_c_d;
      s1_s_q      <= s1_s_d;
      s2_valid_q  <= s2_valid_d;
      s2_byp_q    <= s2_byp_d;
      s2_i_q      <= s2_i_d;
      s2_q_q      <= s2_q_d;
      s2_ic_q     <= s2_ic_d;
      s2_qs_q     <= s2_qs_d;
      s2_qc_q     <= s2_qc_d;
      s2_is_q     <= s2_is_d;
      out_valid_q <= out_valid_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      out_sat_q   <= out_sat_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

endmodule

// File: tb/tb_cfo_mixer.sv
// Directed bench for cfo_mixer: rotation math, rounding, clamping, bypass,
// counter clear, backpressure ordering and asynchronous reset.
module tb_cfo_mixer;

  localparam int DW = 12;
  localparam int NW = 12;
  localparam int CW = 16;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_i;
  logic signed [DW-1:0] in_q;
  logic signed [NW-1:0] ncos;
  logic signed [NW-1:0] nsin;
  logic                 nco_en;
  logic                 bypass;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_i;
  logic signed [DW-1:0] out_q;
  logic [CW-1:0]        sat_cnt;
  logic                 sat_clr;

  int total = 0;
  int bad   = 0;

  cfo_mixer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_i      (in_i),
    .in_q      (in_q),
    .ncos      (ncos),
    .nsin      (nsin),
    .nco_en    (nco_en),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_i     (out_i),
    .out_q     (out_q),
    .sat_cnt   (sat_cnt),
    .sat_clr   (sat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // One sample with out_ready high: checks nco_en, 3-cycle latency, data and sat_cnt.
  task automatic single(input string tag, input int i, input int q, input int c, input int s,
                        input logic byp, input int ei, input int eq, input int esat);
    in_valid  = 1'b1;
    in_i      = DW'(i);
    in_q      = DW'(q);
    ncos      = NW'(c);
    nsin      = NW'(s);
    bypass    = byp;
    out_ready = 1'b1;
    #1 chk({tag, "_nco_en"}, int'(nco_en), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_i     = '0;
    in_q     = '0;
    ncos     = '0;
    nsin     = '0;
    bypass   = 1'b0;
    chk({tag, "_v_n1"}, int'(out_valid), 0);
    @(posedge clk); #1;
    chk({tag, "_v_n2"}, int'(out_valid), 0);
    @(posedge clk); #1;
    chk({tag, "_v_n3"}, int'(out_valid), 1);
    chk({tag, "_i"}, int'(out_i), ei);
    chk({tag, "_q"}, int'(out_q), eq);
    @(posedge clk); #1;
    chk({tag, "_v_after"}, int'(out_valid), 0);
    chk({tag, "_satcnt"}, int'(sat_cnt), esat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_i[8];
    int exp_q[8];
    int sent;
    int rcv;
    int ncnt;
    logic accepted;

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_i      = '0;
    in_q      = '0;
    ncos      = '0;
    nsin      = '0;
    bypass    = 1'b0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_i", int'(out_i), 0);
    chk("rst_out_q", int'(out_q), 0);
    chk("rst_sat_cnt", int'(sat_cnt), 0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_nco_idle", int'(nco_en), 0);
    @(posedge clk); #1;

    // Math, rounding and saturation cases, hand-computed.
    single("ident",  1000, -500, 2047,    0, 1'b0,  1000,  -500, 0);
    single("rot90",  1000, -500,    0, 2047, 1'b0,  -500, -1000, 0);
    single("rhalf",     1,   -1, 1024,    0, 1'b0,     1,     0, 0);
    single("satpos", 2047, 2047, 2047, 2047, 1'b0,  2047,     0, 1);
    single("satmin", -2048, -2048, -2048, -2048, 1'b0, 2047,  0, 2);
    single("satneg", -2048, -2048, 2047, 2047, 1'b0, -2048,   0, 3);
    single("bypass", -2048,  123, 2047, 2047, 1'b1, -2048,  123, 3);

    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("clr_sat_cnt", int'(sat_cnt), 0);

    // Clear held during a saturated transfer must win over the increment.
    sat_clr = 1'b1;
    single("clrprio", 2047, 2047, 2047, 2047, 1'b0, 2047, 0, 0);
    sat_clr = 1'b0;

    // Backpressure: 8 identity-rotated samples, out_ready low for cycles 4..7.
    for (int k = 0; k < 8; k++) begin
      exp_i[k] = 10 * k + 5;
      exp_q[k] = -(20 * k + 3);
    end
    sent = 0;
    rcv  = 0;
    ncnt = 0;
    for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 8);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_i = DW'(exp_i[sent]);
        in_q = DW'(exp_q[sent]);
        ncos = NW'(2047);
        nsin = '0;
      end
      #1;
      if (nco_en) ncnt++;
      if (!out_ready) begin
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_hold_valid", int'(out_valid), 1);
      end
      if (out_valid && rcv < 8) begin
        chk("bp_i", int'(out_i), exp_i[rcv]);
        chk("bp_q", int'(out_q), exp_q[rcv]);
        if (out_ready) rcv++;
      end
      accepted = in_valid & in_ready;
      @(posedge clk); #1;
      if (accepted) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_sent", sent, 8);
    chk("bp_rcv", rcv, 8);
    chk("bp_nco_pulses", ncnt, 8);
    for (int k = 0; k < 2; k++) begin
      chk("bp_no_dup", int'(out_valid), 0);
      @(posedge clk); #1;
    end

    // Make sat_cnt nonzero so reset clearing it is observable.
    single("presat", 2047, 2047, 2047, 2047, 1'b0, 2047, 0, 1);

    // Async reset with three samples in flight.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_i     = DW'(50 + k);
      in_q     = DW'(-60 - k);
      ncos     = NW'(2047);
      nsin     = '0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("ar_pre_valid", int'(out_valid), 1);
    #1 rst = 1'b0;
    #1;
    chk("ar_valid_now", int'(out_valid), 0);
    chk("ar_sat_cnt", int'(sat_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("ar_no_output", int'(out_valid), 0);
    end
    single("recover", 300, -7, 2047, 0, 1'b0, 300, -7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cfo_mixer.md
# cfo_mixer

Carrier-offset derotator sitting directly downstream of the NCO in the CarrierOffset chain. Takes a complex baseband sample stream and the NCO's cosine/sine outputs, computes x·e^(−jθ) through a 3-stage registered complex multiplier with rounding and saturation, and drives the NCO enable so phase advances exactly once per accepted sample. Supports output backpressure, bypass, and a saturation event counter.

## Interface
- DW, 12, sample width (signed two's complement, I and Q)
- NW, 12, NCO word width (signed, matches NCO ncos/nsin)
- FRAC, 11, fractional bits of NCO word (Q1.11: 2047 ≈ +1.0)
- CW, 16, saturation counter width

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- in_i, in_q  in  DW  input I/Q, signed
- ncos, nsin  in  NW  NCO outputs, signed, sampled with the input sample
- nco_en  out  1  NCO advance; equals in_valid & in_ready (combinational)
- bypass  in  1  1: pass input unrotated with same latency
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- out_i, out_q  out  DW  derotated I/Q, signed
- sat_cnt  out  CW  number of output samples with ≥1 saturated component
- sat_clr  in  1  synchronous clear of sat_cnt

## Operation
- Accept: in_valid & in_ready. nco_en pulses the same cycle; NCO presents the next phase on the following cycle.
- Math: out_i = (in_i·ncos + in_q·nsin) >> FRAC; out_q = (in_q·ncos − in_i·nsin) >> FRAC.
- Widths: products DW+NW = 24 bit signed; sums 25 bit signed (no internal overflow, including all-operand −2048).
- Rounding: add 2^(FRAC−1) to 25-bit sum, arithmetic shift right FRAC (round half up).
- Saturation: clamp to [−2^(DW−1), 2^(DW−1)−1] = [−2048, 2047]; sat flag per sample = OR of I and Q clamp.
- sat_cnt: +1 per output transfer (out_valid & out_ready) whose sat flag is set; sticks at 2^CW−1; sat_clr has priority over increment.
- bypass: sampled with input at S1, travels with sample; bypassed sample outputs in_i/in_q unchanged, sat flag 0. Toggling bypass mid-stream affects only samples accepted after the change.
- Stages: S1 register inputs + NCO words + bypass; S2 four products; S3 sum, round, saturate → output regs. Each stage has a valid bit.

## Timing
- Latency: sample accepted in cycle N appears with out_valid in cycle N+3 if out_ready held high.
- Throughput: 1 sample/cycle.
- Stall: advance = out_ready | ~out_valid; all stages and valid bits hold when advance=0. in_ready = advance. Bubbles are not squeezed out while stalled.
- out_i/out_q/out_valid stable while out_valid & ~out_ready.
- Reset (rst=0, async): all valid bits 0, out_i=out_q=0, sat_cnt=0, out_valid=0; in_ready=1 and nco_en follows in_valid once rst=1. Reset mid-stream drops all in-flight samples; no partial output.

## Structure
- Package cfo_pkg: DW, NW, FRAC, CW defaults; sat bounds; round constant.
- Sub-module cfo_rnd_sat: combinational 25-bit → DW round-and-saturate with sat flag, instantiated for I and Q.

## Test plan
- Identity: ncos=2047, nsin=0, in=(1000,−500) → out=(1000,−500) at cycle N+3, sat_cnt=0.
- 90° rotation: ncos=0, nsin=2047, in=(1000,−500) → out=(−500,−1000).
- Saturation: ncos=nsin=2047, in=(2047,2047) → out=(2047,0), sat_cnt=1; all −2048 operands → out=(2047,0), sat_cnt=2.
- Backpressure: stream 8 samples, out_ready low for 4 cycles mid-stream → in_ready low, nco_en pulses exactly 8 times total, outputs held stable, order preserved, none lost/duplicated.
- Bypass/clear: bypass=1, in=(−2048,123), any NCO → out=(−2048,123), sat_cnt unchanged; sat_clr pulse → sat_cnt=0 next cycle.
- Async reset mid-stream: assert rst=0 with 3 samples in flight → out_valid=0 immediately, no outputs after release until new input accepted.
